// File: rtl/lcd_bus_pkg.sv
// Shared definitions for the character-LCD write bus: transfer classes,
// DDRAM address map, blank character and receiver FSM encoding.
package lcd_bus_pkg;

  // Classes of accepted transfers as reported on CMD_CODE.
  localparam logic [3:0] CMD_NONE    = 4'd0;
  localparam logic [3:0] CMD_CLEAR   = 4'd1;
  localparam logic [3:0] CMD_HOME    = 4'd2;
  localparam logic [3:0] CMD_ENTRY   = 4'd3;
  localparam logic [3:0] CMD_DISPCTL = 4'd4;
  localparam logic [3:0] CMD_SHIFT   = 4'd5;
  localparam logic [3:0] CMD_FUNC    = 4'd6;
  localparam logic [3:0] CMD_CGRAM   = 4'd7;
  localparam logic [3:0] CMD_DDRAM   = 4'd8;
  localparam logic [3:0] CMD_DATA    = 4'd9;
  localparam logic [3:0] CMD_NOP     = 4'd15;

  // DDRAM layout: two visible lines of 16 starting at 0x00 and 0x40,
  // each line's address space wrapping at 0x27 / 0x67.
  localparam logic [6:0] LINE1_BASE   = 7'h00;
  localparam logic [6:0] LINE2_BASE   = 7'h40;
  localparam logic [6:0] LINE1_LAST   = 7'h27;
  localparam logic [6:0] LINE2_LAST   = 7'h67;
  localparam int         LINE_LEN     = 16;
  localparam int         SHADOW_DEPTH = 2 * LINE_LEN;
  localparam logic [7:0] BLANK        = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_BUSYW = 2'd2
  } lcd_state_e;

  // Busy period requested by the transfer committed in the previous cycle.
  typedef enum logic [1:0] {
    START_NONE  = 2'd0,
    START_SHORT = 2'd1,
    START_LONG  = 2'd2,
    START_CLEAR = 2'd3
  } start_e;

  // Maps a DDRAM address to {visible, shadow index}; only the first 16
  // addresses of each line are backed by the shadow.
  function automatic logic [5:0] ac_to_index(input logic [6:0] ac);
    logic [5:0] r;
    r = 6'd0;
    if (ac[6:4] == LINE1_BASE[6:4]) begin
      r = {1'b1, 1'b0, ac[3:0]};
    end else if (ac[6:4] == LINE2_BASE[6:4]) begin
      r = {1'b1, 1'b1, ac[3:0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/lcd_ac_step.sv
// Next DDRAM address after a data access, following HD44780 line wrapping.
module lcd_ac_step
  import lcd_bus_pkg::*;
(
  input  logic [6:0] ac,
  input  logic       inc,
  output logic [6:0] ac_next
);

  // Wrap between the two lines at their ends; anything else steps by one.
  always_comb begin
    ac_next = ac;
    if (inc) begin
      if (ac == LINE1_LAST)      ac_next = LINE2_BASE;
      else if (ac == LINE2_LAST) ac_next = LINE1_BASE;
      else                       ac_next = ac + 7'd1;
    end else begin
      if (ac == LINE1_BASE)      ac_next = LINE2_LAST;
      else if (ac == LINE2_BASE) ac_next = LINE1_LAST;
      else                       ac_next = ac - 7'd1;
    end
  end

endmodule

// File: rtl/lcd_bus_receiver.sv
// Responder for the character-LCD write bus: decodes instructions and data,
// keeps a 2x16 DDRAM shadow, address counter, display-on bit and busy flag.
//
// Bus protocol: the master sets RS/RW/DATA and holds LCD_E high for at least
// 3 CLK; the transfer is taken on the falling edge of E (seen 3 CLK after the
// raw fall). There is no ready: a transfer that lands while BUSY is high is
// dropped and recorded in the sticky OVERRUN flag.
module lcd_bus_receiver
  import lcd_bus_pkg::*;
#(
  parameter int BUSY_CYCLES  = 2000,
  parameter int CLEAR_CYCLES = 76500
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       LCD_E,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic [7:0] LCD_DATA,
  input  logic [4:0] RD_ADDR,
  output logic [7:0] RD_DATA,
  output logic [6:0] AC,
  output logic       DISP_ON,
  output logic       BUSY,
  output logic       CMD_VALID,
  output logic [3:0] CMD_CODE,
  output logic       OVERRUN,
  output lcd_state_e DBG_STATE
);

  localparam int CNT_MAX    = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);
  localparam int CLEAR_TAIL = CLEAR_CYCLES - SHADOW_DEPTH;

  logic [1:0] e_sync_q, rs_sync_q, rw_sync_q;
  logic [7:0] data_s1_q, data_s2_q;
  logic       e_prev_q;
  logic       cap_rs_q, cap_rs_d, cap_rw_q, cap_rw_d;
  logic [7:0] cap_data_q, cap_data_d;
  lcd_state_e state_q, state_d;
  start_e     start_q, start_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0] ac_q, ac_d, ac_stepped;
  logic       id_q, id_d, disp_on_q, disp_on_d;
  logic       cmd_valid_q, cmd_valid_d, overrun_q, overrun_d;
  logic [3:0] cmd_code_q, cmd_code_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic [7:0] shadow_q [SHADOW_DEPTH];
  logic [7:0] shadow_d [SHADOW_DEPTH];
  logic [5:0] ac_map;
  logic       e_fall, busy_now;

  lcd_ac_step u_ac_step (.ac(ac_q), .inc(id_q), .ac_next(ac_stepped));

  // Two-flop synchronizers for the asynchronous bus, plus E edge history.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      e_sync_q  <= '0;
      rs_sync_q <= '0;
      rw_sync_q <= '0;
      data_s1_q <= '0;
      data_s2_q <= '0;
      e_prev_q  <= 1'b0;
    end else begin
      e_sync_q  <= {e_sync_q[0], LCD_E};
      rs_sync_q <= {rs_sync_q[0], LCD_RS};
      rw_sync_q <= {rw_sync_q[0], LCD_RW};
      data_s1_q <= LCD_DATA;
      data_s2_q <= data_s1_q;
      e_prev_q  <= e_sync_q[1];
    end
  end

  assign e_fall   = e_prev_q & ~e_sync_q[1];
  assign busy_now = (state_q != ST_IDLE) || (start_q != START_NONE);
  assign ac_map   = ac_to_index(ac_q);

  // Capture, decode and commit transfers; run the clear / busy FSM.
  always_comb begin
    cap_rs_d    = cap_rs_q;
    cap_rw_d    = cap_rw_q;
    cap_data_d  = cap_data_q;
    state_d     = state_q;
    start_d     = START_NONE;
    cnt_d       = cnt_q;
    ac_d        = ac_q;
    id_d        = id_q;
    disp_on_d   = disp_on_q;
    cmd_valid_d = 1'b0;
    cmd_code_d  = cmd_code_q;
    overrun_d   = overrun_q;
    shadow_d    = shadow_q;
    rd_data_d   = shadow_q[RD_ADDR];

    if (e_sync_q[1]) begin
      cap_rs_d   = rs_sync_q[1];
      cap_rw_d   = rw_sync_q[1];
      cap_data_d = data_s2_q;
    end

    if (e_fall && !cap_rw_q) begin
      if (busy_now) begin
        overrun_d = 1'b1;
      end else begin
        cmd_valid_d = 1'b1;
        start_d     = START_SHORT;
        if (cap_rs_q) begin
          cmd_code_d = CMD_DATA;
          if (ac_map[5]) shadow_d[ac_map[4:0]] = cap_data_q;
          ac_d = ac_stepped;
        end else begin
          casez (cap_data_q)
            8'b1???????: begin cmd_code_d = CMD_DDRAM; ac_d = cap_data_q[6:0]; end
            8'b01??????: cmd_code_d = CMD_CGRAM;
            8'b001?????: cmd_code_d = CMD_FUNC;
            8'b0001????: cmd_code_d = CMD_SHIFT;
            8'b00001???: begin cmd_code_d = CMD_DISPCTL; disp_on_d = cap_data_q[2]; end
            8'b000001??: begin cmd_code_d = CMD_ENTRY; id_d = cap_data_q[1]; end
            8'b0000001?: begin cmd_code_d = CMD_HOME; ac_d = LINE1_BASE; start_d = START_LONG; end
            8'b00000001: begin
              cmd_code_d = CMD_CLEAR;
              ac_d       = LINE1_BASE;
              id_d       = 1'b1;
              start_d    = START_CLEAR;
            end
            default:     begin cmd_code_d = CMD_NOP; start_d = START_NONE; end
          endcase
        end
      end
    end

    case (state_q)
      ST_IDLE: begin
        case (start_q)
          START_SHORT: begin state_d = ST_BUSYW; cnt_d = CNT_W'(BUSY_CYCLES - 1); end
          START_LONG:  begin state_d = ST_BUSYW; cnt_d = CNT_W'(CLEAR_CYCLES - 1); end
          START_CLEAR: begin state_d = ST_CLEAR; cnt_d = '0; end
          default:     ;
        endcase
      end
      ST_CLEAR: begin
        shadow_d[cnt_q[4:0]] = BLANK;
        if (cnt_q[4:0] == 5'd31) begin
          if (CLEAR_TAIL == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_BUSYW;
            cnt_d   = CNT_W'(CLEAR_TAIL - 1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_BUSYW: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset blanks the shadow and aborts any clear or busy count.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      cap_rs_q    <= 1'b0;
      cap_rw_q    <= 1'b0;
      cap_data_q  <= '0;
      state_q     <= ST_IDLE;
      start_q     <= START_NONE;
      cnt_q       <= '0;
      ac_q        <= LINE1_BASE;
      id_q        <= 1'b1;
      disp_on_q   <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= CMD_NONE;
      overrun_q   <= 1'b0;
      rd_data_q   <= BLANK;
      for (int i = 0; i < SHADOW_DEPTH; i++) shadow_q[i] <= BLANK;
    end else begin
      cap_rs_q    <= cap_rs_d;
      cap_rw_q    <= cap_rw_d;
      cap_data_q  <= cap_data_d;
      state_q     <= state_d;
      start_q     <= start_d;
      cnt_q       <= cnt_d;
      ac_q        <= ac_d;
      id_q        <= id_d;
      disp_on_q   <= disp_on_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_code_q  <= cmd_code_d;
      overrun_q   <= overrun_d;
      rd_data_q   <= rd_data_d;
      for (int i = 0; i < SHADOW_DEPTH; i++) shadow_q[i] <= shadow_d[i];
    end
  end

  assign RD_DATA   = rd_data_q;
  assign AC        = ac_q;
  assign DISP_ON   = disp_on_q;
  assign BUSY      = (state_q != ST_IDLE);
  assign CMD_VALID = cmd_valid_q;
  assign CMD_CODE  = cmd_code_q;
  assign OVERRUN   = overrun_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Directed bench for lcd_bus_receiver with shortened busy periods.
module tb_lcd_bus_receiver;
  import lcd_bus_pkg::*;

  localparam int BUSY_N  = 120;
  localparam int CLEAR_N = 400;

  logic       clk, rst_n;
  logic       lcd_e, lcd_rs, lcd_rw;
  logic [7:0] lcd_data;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic [6:0] ac;
  logic       disp_on, busy, cmd_valid, overrun;
  logic [3:0] cmd_code;
  lcd_state_e dbg_state;

  int checks = 0;
  int errors = 0;

  lcd_bus_receiver #(.BUSY_CYCLES(BUSY_N), .CLEAR_CYCLES(CLEAR_N)) dut (
    .CLK(clk), .RESETN(rst_n), .LCD_E(lcd_e), .LCD_RS(lcd_rs), .LCD_RW(lcd_rw),
    .LCD_DATA(lcd_data), .RD_ADDR(rd_addr), .RD_DATA(rd_data), .AC(ac),
    .DISP_ON(disp_on), .BUSY(busy), .CMD_VALID(cmd_valid), .CMD_CODE(cmd_code),
    .OVERRUN(overrun), .DBG_STATE(dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one bus transfer; called and returns on a falling clock edge.
  task automatic send(input logic rs, input logic rw, input logic [7:0] d);
    lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_e = 1'b1;
    repeat (4) @(negedge clk);
    lcd_e = 1'b0;
  endtask

  // Move to the commit cycle (3 edges after the E fall) and check the pulse.
  task automatic wait_commit(input string tag, input logic exp_valid, input logic [3:0] exp_code);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check({tag, "_valid"}, 32'(cmd_valid), 32'(exp_valid));
    if (exp_valid) check({tag, "_code"}, 32'(cmd_code), 32'(exp_code));
  endtask

  // From the commit cycle, count how many cycles BUSY stays high.
  task automatic measure_busy(input string tag, input int exp_n);
    int n;
    check({tag, "_busy_at_commit"}, 32'(busy), 32'd0);
    n = 0;
    @(negedge clk);
    while (busy && n < 5000) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_busy_len"}, 32'(n), 32'(exp_n));
  endtask

  task automatic read_check(input int idx, input logic [7:0] exp);
    rd_addr = 5'(idx);
    @(negedge clk);
    check($sformatf("rd_idx%0d", idx), 32'(rd_data), 32'(exp));
  endtask

  task automatic op(input string tag, input logic rs, input logic [7:0] d,
                    input logic [3:0] exp_code, input int exp_busy);
    send(rs, 1'b0, d);
    wait_commit(tag, 1'b1, exp_code);
    measure_busy(tag, exp_busy);
  endtask

  // Directed sequence
  initial begin
    int n;
    rst_n = 1'b0; lcd_e = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0;
    lcd_data = 8'h00; rd_addr = 5'd0;
    repeat (3) @(negedge clk);
    check("rst_ac", 32'(ac), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_disp_on", 32'(disp_on), 32'h0);
    check("rst_cmd_valid", 32'(cmd_valid), 32'h0);
    check("rst_cmd_code", 32'(cmd_code), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_rd_data", 32'(rd_data), 32'h20);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 32; i++) read_check(i, 8'h20);

    // Display on, then two characters on line 1
    op("dispctl", 1'b0, 8'h0C, 4'd4, BUSY_N);
    check("disp_on", 32'(disp_on), 32'h1);
    op("data_A", 1'b1, 8'h41, 4'd9, BUSY_N);
    op("data_B", 1'b1, 8'h42, 4'd9, BUSY_N);
    check("ac_after_AB", 32'(ac), 32'h02);
    read_check(0, 8'h41);
    read_check(1, 8'h42);
    read_check(2, 8'h20);

    // Last visible cell of line 2, then the unmapped end of line 1
    op("setaddr_4f", 1'b0, 8'hCF, 4'd8, BUSY_N);
    check("ac_4f", 32'(ac), 32'h4F);
    op("data_Z", 1'b1, 8'h5A, 4'd9, BUSY_N);
    check("ac_50", 32'(ac), 32'h50);
    read_check(31, 8'h5A);
    op("setaddr_27", 1'b0, 8'hA7, 4'd8, BUSY_N);
    check("ac_27", 32'(ac), 32'h27);
    op("data_drop", 1'b1, 8'h31, 4'd9, BUSY_N);
    check("ac_wrap_40", 32'(ac), 32'h40);
    read_check(15, 8'h20);

    // Decrement mode wraps line 2 start back to 0x27
    op("entry_dec", 1'b0, 8'h04, 4'd3, BUSY_N);
    op("setaddr_40", 1'b0, 8'hC0, 4'd8, BUSY_N);
    op("data_3", 1'b1, 8'h33, 4'd9, BUSY_N);
    check("ac_dec_27", 32'(ac), 32'h27);
    read_check(16, 8'h33);

    // Read transfers and the all-zero instruction have no effect
    send(1'b1, 1'b1, 8'h55);
    wait_commit("rw_read", 1'b0, 4'd0);
    check("rw_read_busy", 32'(busy), 32'h0);
    check("rw_read_ac", 32'(ac), 32'h27);
    op("nop", 1'b0, 8'h00, 4'd15, 0);
    check("cmd_code_hold", 32'(cmd_code), 32'd15);

    // Clear: watch index 31 flip between commit+33 and commit+34
    rd_addr = 5'd31;
    send(1'b0, 1'b0, 8'h01);
    wait_commit("clear", 1'b1, 4'd1);
    check("clear_rd_before", 32'(rd_data), 32'h5A);
    check("clear_ac", 32'(ac), 32'h0);
    n = 0;
    @(negedge clk);
    while (busy && n < 5000) begin
      n++;
      if (n == 1)  check("clear_state_1", 32'(dbg_state), 32'(ST_CLEAR));
      if (n == 33) check("clear_idx31_old", 32'(rd_data), 32'h5A);
      if (n == 34) begin
        check("clear_idx31_new", 32'(rd_data), 32'h20);
        check("clear_state_34", 32'(dbg_state), 32'(ST_BUSYW));
      end
      @(negedge clk);
    end
    check("clear_busy_len", 32'(n), 32'(CLEAR_N));
    for (int i = 0; i < 32; i++) read_check(i, 8'h20);
    op("data_D", 1'b1, 8'h44, 4'd9, BUSY_N);
    check("ac_inc_after_clear", 32'(ac), 32'h01);
    read_check(0, 8'h44);

    // Home takes the long busy period
    op("home", 1'b0, 8'h02, 4'd2, CLEAR_N);
    check("ac_home", 32'(ac), 32'h00);
    read_check(0, 8'h44);

    // Write while busy is dropped and flagged
    send(1'b1, 1'b0, 8'h77);
    wait_commit("w1", 1'b1, 4'd9);
    repeat (40) @(negedge clk);
    send(1'b1, 1'b0, 8'h78);
    wait_commit("overrun", 1'b0, 4'd0);
    check("overrun_flag", 32'(overrun), 32'h1);
    check("overrun_busy", 32'(busy), 32'h1);
    n = 0;
    while (busy && n < 5000) begin
      n++;
      @(negedge clk);
    end
    check("overrun_ac", 32'(ac), 32'h01);
    read_check(0, 8'h77);
    read_check(1, 8'h20);
    check("overrun_sticky", 32'(overrun), 32'h1);

    // Reset in the middle of a clear
    op("setaddr_4f_b", 1'b0, 8'hCF, 4'd8, BUSY_N);
    op("data_f", 1'b1, 8'h66, 4'd9, BUSY_N);
    send(1'b0, 1'b0, 8'h01);
    wait_commit("clear2", 1'b1, 4'd1);
    repeat (10) @(negedge clk);
    check("clear2_busy", 32'(busy), 32'h1);
    check("clear2_state", 32'(dbg_state), 32'(ST_CLEAR));
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_overrun", 32'(overrun), 32'h0);
    check("mid_rst_code", 32'(cmd_code), 32'h0);
    check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 32; i++) read_check(i, 8'h20);
    check("post_rst_busy", 32'(busy), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
